io_pin_mux: RTL

Pad-ownership controller for the user-project `mprj_io` pins. Each pin is shared between up to four peripheral sources (GPIO, UART, SPI, PWM) and is granted to exactly one owner at a time. Ownership is configured over Wishbone. Every ownership change inserts a tristate park interval so two drivers never overlap on a pad. The block sits between the peripheral bank and the Caravel pad signals (`io_out`/`io_oeb`/`io_in`).

---
 rtl/io_pin_mux.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/io_pin_mux.sv
// io_pin_mux: pad-ownership controller for the mprj_io pins.
// Each pin is granted to one of four sources (0 GPIO, 1 UART, 2 SPI, 3 PWM). Owners are
// selected over Wishbone. Any ownership change parks the pad (tristate) for PARK_CYCLES
// cycles so two sources never drive the same pad.
// Optional feature macro: PINMUX_LOCK_EN implements the sticky LOCK register at 0x08.

module io_pin_mux #(
   parameter int unsigned PIN_COUNT   = 32,
   parameter int unsigned PARK_CYCLES = 2
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic                   wb_cyc_i,
   input  logic                   wb_stb_i,
   input  logic                   wb_we_i,
   input  logic [3:0]             wb_sel_i,
   input  logic [7:0]             wb_adr_i,
   input  logic [31:0]            wb_data_i,
   output logic                   wb_ack_o,
   output logic [31:0]            wb_data_o,
   input  logic [4*PIN_COUNT-1:0] src_out_i,
   input  logic [4*PIN_COUNT-1:0] src_oeb_i,
   output logic [4*PIN_COUNT-1:0] src_in_o,
   output logic [PIN_COUNT-1:0]   io_out,
   output logic [PIN_COUNT-1:0]   io_oeb,
   input  logic [PIN_COUNT-1:0]   io_in
);

   typedef enum logic {StActive, StPark} pin_state_e;

   // SEL bits belonging to pins that exist; the rest read 0 and ignore writes.
   localparam logic [63:0] SelMask =
      (PIN_COUNT >= 32) ? {64{1'b1}} : ((64'd1 << (2 * PIN_COUNT)) - 64'd1);
   localparam logic [3:0]  ParkLoad = 4'(PARK_CYCLES);

   logic        ack_q;
   logic [31:0] rdata_q;
   logic [31:0] rdata;
   logic        req;
   logic        wr_req;
   logic [5:0]  word;
   logic        locked;
   logic [63:0] sel_q;
   logic [63:0] sel_d;
   logic [63:0] sel_wmask;
   logic [31:0] status;
   logic        unused_adr;

   pin_state_e  state_q [PIN_COUNT];
   pin_state_e  state_d [PIN_COUNT];
   logic [1:0]  owner_q [PIN_COUNT];
   logic [1:0]  owner_d [PIN_COUNT];
   logic [3:0]  cnt_q   [PIN_COUNT];
   logic [3:0]  cnt_d   [PIN_COUNT];

   assign unused_adr = ^wb_adr_i[1:0];
   assign req        = wb_cyc_i & wb_stb_i & ~ack_q;
   assign wr_req     = req & wb_we_i;
   assign word       = wb_adr_i[7:2];

`ifdef PINMUX_LOCK_EN
   logic lock_q;

   // Sticky lock: set by writing 1 to bit 0, cleared only by reset.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         lock_q <= 1'b0;
      end else if (wr_req && word == 6'd2 && wb_sel_i[0] && wb_data_i[0]) begin
         lock_q <= 1'b1;
      end
   end

   assign locked = lock_q;
`else
   assign locked = 1'b0;
`endif

   // Byte-enabled update of the SEL0/SEL1 pair, viewed as one 64-bit field array.
   always_comb begin
      sel_wmask = '0;
      if (wr_req && !locked && word[5:1] == 5'd0) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (wb_sel_i[b]) begin
               if (word[0]) begin
                  sel_wmask[32 + 8*b +: 8] = 8'hFF;
               end else begin
                  sel_wmask[8*b +: 8] = 8'hFF;
               end
            end
         end
      end
      sel_d = ((sel_q & ~sel_wmask) | ({wb_data_i, wb_data_i} & sel_wmask)) & SelMask;
   end

   // SEL register.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         sel_q <= '0;
      end else begin
         sel_q <= sel_d;
      end
   end

   // Per-pin park FSM; a field counts as written when its byte lane is enabled.
   always_comb begin
      for (int unsigned p = 0; p < PIN_COUNT; p++) begin
         state_d[p] = state_q[p];
         owner_d[p] = owner_q[p];
         cnt_d[p]   = cnt_q[p];
         unique case (state_q[p])
            StActive: begin
               if (sel_wmask[2*p] && sel_d[2*p +: 2] != owner_q[p]) begin
                  state_d[p] = StPark;
                  cnt_d[p]   = ParkLoad;
               end
            end
            StPark: begin
               // Any write during park restarts it, even one restoring the old owner.
               if (sel_wmask[2*p]) begin
                  cnt_d[p] = ParkLoad;
               end else if (cnt_q[p] == 4'd1) begin
                  state_d[p] = StActive;
                  owner_d[p] = sel_q[2*p +: 2];
                  cnt_d[p]   = 4'd0;
               end else begin
                  cnt_d[p] = cnt_q[p] - 4'd1;
               end
            end
            default: begin
               state_d[p] = StActive;
            end
         endcase
      end
   end

   // Per-pin state registers.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         for (int unsigned p = 0; p < PIN_COUNT; p++) begin
            state_q[p] <= StActive;
            owner_q[p] <= 2'd0;
            cnt_q[p]   <= 4'd0;
         end
      end else begin
         for (int unsigned p = 0; p < PIN_COUNT; p++) begin
            state_q[p] <= state_d[p];
            owner_q[p] <= owner_d[p];
            cnt_q[p]   <= cnt_d[p];
         end
      end
   end

   // Parking flags for STATUS.
   always_comb begin
      status = '0;
      for (int unsigned p = 0; p < PIN_COUNT; p++) begin
         status[p] = (state_q[p] == StPark);
      end
   end

   // Register read mux.
   always_comb begin
      rdata = '0;
      case (word)
         6'd0:    rdata = sel_q[31:0];
         6'd1:    rdata = sel_q[63:32];
         6'd2:    rdata = {31'd0, locked};
         6'd3:    rdata = status;
         default: rdata = '0;
      endcase
   end

   // Single-cycle ack one cycle after acceptance; read data only alongside ack.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         ack_q   <= req;
         rdata_q <= (req && !wb_we_i) ? rdata : 32'd0;
      end
   end

   assign wb_ack_o  = ack_q;
   assign wb_data_o = rdata_q;

   // Pad and source-input routing; parked pins tristate and all their sources see idle-high.
   always_comb begin
      io_out   = '0;
      io_oeb   = '1;
      src_in_o = '1;
      for (int unsigned p = 0; p < PIN_COUNT; p++) begin
         if (state_q[p] == StActive) begin
            for (int unsigned s = 0; s < 4; s++) begin
               if (owner_q[p] == 2'(s)) begin
                  io_out[p]                 = src_out_i[s*PIN_COUNT + p];
                  io_oeb[p]                 = src_oeb_i[s*PIN_COUNT + p];
                  src_in_o[s*PIN_COUNT + p] = io_in[p];
               end
            end
         end
      end
   end

endmodule
